tile_fetch_unit: RTL

Upstream feeder for the NPU. On a start request it reads one TILE x TILE submatrix of the 8-bit source image from the dual-port image ROM (port A), one address per cycle. It assembles the submatrix, zero-extended to 16-bit signed, into a flattened matrix register and pulses done. This replaces the per-pixel read/store loop in the top-level control FSM with a pipelined fetch of 1 pixel/cycle, and adds a ROM access counter for performance monitoring.

---
 rtl/tile_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tile_fetch_unit.sv
// Fetches one TILE x TILE block of the source image from ROM port A at one pixel per
// cycle and assembles it, zero-extended, into a flattened matrix register.
module tile_fetch_unit #(
   parameter int IMG_W  = 400,
   parameter int IMG_H  = 400,
   parameter int TILE   = 10,
   parameter int ADDR_W = 18,
   parameter int PIX_W  = 8,
   parameter int OUT_W  = 16,
   parameter int RD_LAT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [5:0]                  tile_x,
   input  logic [5:0]                  tile_y,
   input  logic                        abort,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [ADDR_W-1:0]           rom_addr,
   input  logic [PIX_W-1:0]            rom_data,
   output logic [TILE*TILE*OUT_W-1:0]  tile_data,
   input  logic                        cnt_clr,
   output logic [31:0]                 access_count
);
   // state   | meaning
   // S_IDLE  | waiting for start
   // S_ISSUE | presenting one ROM address per cycle
   // S_DRAIN | waiting for outstanding ROM returns
   // S_DONE  | one-cycle done pulse
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int NPIX  = TILE * TILE;
   localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int COL_W = (TILE > 1) ? $clog2(TILE) : 1;

   logic [1:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [COL_W-1:0]  col;
   logic [ADDR_W-1:0] row_base;
   logic              pipe_v   [RD_LAT];
   logic [IDX_W-1:0]  pipe_idx [RD_LAT];

   logic              start_ok;
   logic [ADDR_W-1:0] base;
   logic              pend;
   logic              abort_act;

   assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign abort_act = abort && busy;

   // Only place a multiply appears; the walk itself is add-only.
   always_comb begin
      start_ok = (32'(tile_x) < 32'(IMG_W / TILE)) && (32'(tile_y) < 32'(IMG_H / TILE));
      base     = ADDR_W'(tile_y) * ADDR_W'(TILE * IMG_W) + ADDR_W'(tile_x) * ADDR_W'(TILE);
   end

   // The final stage is exiting this edge, so only earlier stages count as pending.
   always_comb begin
      pend = 1'b0;
      for (int i = 0; i < RD_LAT - 1; i++) pend = pend | pipe_v[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         err          <= 1'b0;
         rom_addr     <= '0;
         row_base     <= '0;
         idx          <= '0;
         col          <= '0;
         access_count <= '0;
         tile_data    <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i]   <= 1'b0;
            pipe_idx[i] <= '0;
         end
      end else begin
         err <= 1'b0;

         pipe_v[0]   <= (state == S_ISSUE) && !abort;
         pipe_idx[0] <= idx;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1] && !abort_act;
            pipe_idx[i] <= pipe_idx[i-1];
         end

         if (pipe_v[RD_LAT-1] && !abort_act)
            tile_data[int'(pipe_idx[RD_LAT-1])*OUT_W +: OUT_W] <= {{(OUT_W-PIX_W){1'b0}}, rom_data};

         if (cnt_clr)
            access_count <= '0;
         else if (state == S_ISSUE && access_count != '1)
            access_count <= access_count + 32'd1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     rom_addr <= base;
                     row_base <= base;
                     idx      <= '0;
                     col      <= '0;
                     state    <= S_ISSUE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (idx == IDX_W'(NPIX - 1)) begin
                  state <= S_DRAIN;
               end else begin
                  idx <= idx + 1'b1;
                  if (col == COL_W'(TILE - 1)) begin
                     col      <= '0;
                     row_base <= row_base + ADDR_W'(IMG_W);
                     rom_addr <= row_base + ADDR_W'(IMG_W);
                  end else begin
                     col      <= col + 1'b1;
                     rom_addr <= rom_addr + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (abort)      state <= S_IDLE;
               else if (!pend) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
